output_writeback_unit: RTL
==========================

// Module: output_writeback_unit
// PURPOSE
//  Drains the PE-array accumulator columns into activation memory. Each column is
//  requantised, saturated and passed through a configurable activation, then packed
//  into one MEM_BW word. Words are issued to the memory write port under valid/ready.
//  It generalises the fixed 16-lane ReLU+packer path: lane/column count, rounding
//  shift, saturation, activation modes and write back-pressure are all configurable.
// PARAMETERS
//  IO_DATA_WIDTH   8    output element width (signed)
//  ACC_WIDTH       32   accumulator width per PE (signed)
//  NB_LANES        16   PE rows = elements per packed word; NB_LANES*IO_DATA_WIDTH == MEM_BW
//  NB_COLUMNS      16   PE columns = words per drain
//  MEM_BW          128  memory word width
//  ADDR_WIDTH      14   activation memory address width
//  SHIFT_WIDTH     5    width of shift_amount
// PORTS
//  clk            in   1                   clock
//  arst_n_in      in   1                   reset: synchronous, active-low
//  start          in   1                   drain request pulse, sampled in IDLE only
//  base_addr      in   ADDR_WIDTH          address of column 0, captured on start
//  addr_stride    in   ADDR_WIDTH          address increment per column, captured on start
//  mode           in   2                   00 none, 01 ReLU, 10 ReLU+cap, 11 legacy; captured on start
//  shift_amount   in   SHIFT_WIDTH         arithmetic right shift with round-half-up, captured on start
//  relu_cap       in   IO_DATA_WIDTH       upper clip for mode 10 (unsigned, <= 2^(W-1)-1), captured on start
//  col_sel        out  $clog2(NB_COLUMNS)  accumulator column currently selected
//  col_acc        in   NB_LANES*ACC_WIDTH  accumulators of column col_sel; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//  wr_valid       out  1                   write request valid
//  wr_ready       in   1                   memory port accepts this cycle
//  wr_addr        out  ADDR_WIDTH          write address
//  wr_data        out  MEM_BW              packed word; lane i at [i*IO_DATA_WIDTH +: IO_DATA_WIDTH]
//  busy           out  1                   high in RUN and FLUSH
//  done           out  1                   one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset (arst_n_in=0 at a clk edge): state=IDLE; col counter, col_sel, wr_valid, wr_addr,
//   wr_data, busy and done are all 0. A reset mid-drain abandons the drain; no further writes.
//  FSM:
//   IDLE : start=1 -> capture config, col=0, go to RUN.
//   RUN  : a slot is free when wr_valid=0 or wr_ready=1. On a free slot, load wr_data from
//          col_acc, set wr_addr = base+col*stride (mod 2^ADDR_WIDTH) and wr_valid=1, then col++.
//          After column NB_COLUMNS-1 is loaded -> FLUSH.
//   FLUSH: on wr_valid&&wr_ready -> wr_valid=0, done=1 for 1 cycle, go to IDLE.
//  start in RUN or FLUSH is ignored. start in the done cycle (state already IDLE) is accepted.
//  col_sel = col, registered. col_acc is sampled combinationally in the same cycle as the load.
//  Latency: start at edge N -> first wr_valid at edge N+2. With wr_ready=1 throughout, one word
//   per cycle. done is asserted NB_COLUMNS+2 cycles after start.
//  Back-pressure: while wr_valid=1 and wr_ready=0, wr_data and wr_addr are held stable and col
//   does not advance. No word is ever dropped or duplicated.
//  Per-lane arithmetic (modes 00-10):
//   - r = (acc + (shift ? 2^(shift-1) : 0)) >>> shift, computed at ACC_WIDTH+1 bits so there is
//     no overflow.
//   - sat(r) clamps r to [-2^(W-1), 2^(W-1)-1].
//   - Mode 01 then maps negatives to 0. Mode 10 then clamps to [0, relu_cap].
//  Mode 11 (legacy): take the low W bits of acc, ignore shift; if the MSB of that value is 1,
//   output 0.
//  Sum of shift_amount values >= ACC_WIDTH is legal: r becomes 0 or -1 before rounding.
// TESTING
//  1. Reset mid-RUN with wr_ready=1 at column 5 -> wr_valid=0 the next cycle; busy=0; no done;
//     a new start drains all columns from 0.
//  2. mode=00, shift=0, NB_COLUMNS=16, ready=1, lane acc=i*10-50 -> 16 words; lanes saturate
//     at 127/-128 where needed; done 18 cycles after start.
//  3. mode=01, shift=4, acc=+24/-24/+23 -> lanes 2/0/1 (round half-up: 24+8>>4=2, 23+8>>4=1).
//  4. mode=10, relu_cap=6, acc=1000, shift=0 -> 6; mode=11, acc=0x0000_0181 -> 0 (low byte
//     0x81, MSB set); acc=0x0000_0145 -> 0x45.
//  5. base=0x3FF0, stride=0x20 with ready toggling 1,0,0,1 -> addresses 0x3FF0, 0x0010 (wrap),
//     ...; data and address held during stalls; exactly 16 handshakes.
//  6. start pulsed during RUN and FLUSH -> ignored; start in the done cycle -> new drain begins.

Source files
------------

// File: rtl/output_writeback_unit.sv
// output_writeback_unit: drains PE-array accumulator columns into activation memory,
// requantising, saturating and activating each lane before packing one word per column.
module output_writeback_unit #(
    parameter int IO_DATA_WIDTH = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int NB_LANES      = 16,
    parameter int NB_COLUMNS    = 16,
    parameter int MEM_BW        = 128,
    parameter int ADDR_WIDTH    = 14,
    parameter int SHIFT_WIDTH   = 5
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH-1:0]         addr_stride,
    input  logic [1:0]                    mode,
    input  logic [SHIFT_WIDTH-1:0]        shift_amount,
    input  logic [IO_DATA_WIDTH-1:0]      relu_cap,
    output logic [$clog2(NB_COLUMNS)-1:0] col_sel,
    input  logic [NB_LANES*ACC_WIDTH-1:0] col_acc,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [MEM_BW-1:0]             wr_data,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = $clog2(NB_COLUMNS);
    localparam int XW = ACC_WIDTH + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2;
    localparam logic [CW-1:0] LAST_COL = CW'(NB_COLUMNS - 1);
    localparam logic signed [XW-1:0] MAX_X = $signed({{(XW-IO_DATA_WIDTH+1){1'b0}}, {(IO_DATA_WIDTH-1){1'b1}}});
    localparam logic signed [XW-1:0] MIN_X = ~MAX_X;
    localparam logic [IO_DATA_WIDTH-1:0] MAX_W = {1'b0, {(IO_DATA_WIDTH-1){1'b1}}};
    localparam logic [IO_DATA_WIDTH-1:0] MIN_W = ~MAX_W;
    localparam logic [XW-1:0] ONE_X = XW'(1);

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [1:0]               mode_q, mode_d;
    logic [SHIFT_WIDTH-1:0]   shift_q, shift_d;
    logic [IO_DATA_WIDTH-1:0] cap_q, cap_d;
    logic [ADDR_WIDTH-1:0]    stride_q, stride_d, next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [MEM_BW-1:0]        wr_data_q, wr_data_d, lane_word;
    logic                     wr_valid_q, wr_valid_d, done_q, done_d;

    // Extra sign bit keeps acc + rounding constant from overflowing before the shift.
    function automatic logic [IO_DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc,
        input logic [1:0] md, input logic [SHIFT_WIDTH-1:0] sh, input logic [IO_DATA_WIDTH-1:0] cap);
        logic signed [XW-1:0] rnd, r;
        logic [IO_DATA_WIDTH-1:0] s, relu, capped;
        rnd = (sh == '0) ? '0 : $signed(ONE_X << (sh - SHIFT_WIDTH'(1)));
        r = $signed({acc[ACC_WIDTH-1], acc}) + rnd;
        r = r >>> sh;
        s = (r > MAX_X) ? MAX_W : (r < MIN_X) ? MIN_W : r[IO_DATA_WIDTH-1:0];
        relu = s[IO_DATA_WIDTH-1] ? '0 : s;
        capped = (relu > cap) ? cap : relu;
        return (md == 2'd3) ? (acc[IO_DATA_WIDTH-1] ? '0 : acc[IO_DATA_WIDTH-1:0]) :
               (md == 2'd2) ? capped : (md == 2'd1) ? relu : s;
    endfunction

    always_comb begin
        lane_word = '0;
        for (int i = 0; i < NB_LANES; i++)
            lane_word[i*IO_DATA_WIDTH +: IO_DATA_WIDTH] =
                requant(col_acc[i*ACC_WIDTH +: ACC_WIDTH], mode_q, shift_q, cap_q);
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        cap_d       = cap_q;
        stride_d    = stride_q;
        next_addr_d = next_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = wr_valid_q;
        done_d      = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d     = S_RUN;
                col_d       = '0;
                mode_d      = mode;
                shift_d     = shift_amount;
                cap_d       = relu_cap;
                stride_d    = addr_stride;
                next_addr_d = base_addr;
            end
        end else if (state_q == S_RUN) begin
            if (!wr_valid_q || wr_ready) begin
                wr_valid_d  = 1'b1;
                wr_data_d   = lane_word;
                wr_addr_d   = next_addr_q;
                next_addr_d = next_addr_q + stride_q;
                col_d       = col_q + CW'(1);
                state_d     = (col_q == LAST_COL) ? S_FLUSH : S_RUN;
            end
        end else if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            cap_q       <= '0;
            stride_q    <= '0;
            next_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            cap_q       <= cap_d;
            stride_q    <= stride_d;
            next_addr_q <= next_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            done_q      <= done_d;
        end
    end

    assign col_sel  = col_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
